// File: rtl/instruction_loader.sv
// instruction_loader: byte-serial loader filling a word-addressed instruction memory with a combinational fetch port
module instruction_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    input  logic [8:0]  load_count,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic [31:0] program_counter,
    output logic [31:0] instruction,
    output logic        busy,
    output logic        done,
    output logic [8:0]  words_loaded
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t state, next_state;
    logic [31:0] mem [DEPTH];
    logic [ADDR_W-1:0] waddr;
    logic [1:0] bcnt;
    logic [8:0] target;
    logic [23:0] shift;
    logic [8:0] count_clamped;
    logic accept, word_done;

    // Counts above DEPTH are clamped so the write address can never wrap.
    assign count_clamped = (load_count > 9'(DEPTH)) ? 9'(DEPTH) : load_count;
    // load_start outranks a handshake on the same cycle, so that byte is dropped.
    assign accept = (state == LOAD) && byte_valid && !load_start;
    assign word_done = accept && (bcnt == 2'd3);

    // State register; reset forces IDLE immediately.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= next_state;

    // Next state and state-decoded outputs; completion of the last word enters DONE on its write edge.
    always_comb begin
        next_state = state;
        byte_ready = (state == LOAD);
        busy = (state == LOAD);
        done = (state == DONE);
        if (load_start) next_state = (count_clamped == 9'd0) ? DONE : LOAD;
        else if (word_done && (words_loaded + 9'd1 == target)) next_state = DONE;
    end

    // Session counters and the big-endian byte assembly register.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            waddr <= '0;
            bcnt <= '0;
            words_loaded <= '0;
            target <= '0;
            shift <= '0;
        end else if (load_start) begin
            waddr <= '0;
            bcnt <= '0;
            words_loaded <= '0;
            target <= count_clamped;
        end else if (accept) begin
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
                waddr <= waddr + 1'b1;
                words_loaded <= words_loaded + 9'd1;
            end else shift <= {shift[15:0], byte_in};
        end

    // Memory write on the fourth byte of each word; contents survive reset.
    always_ff @(posedge clk)
        if (word_done) mem[waddr] <= {shift, byte_in};

    // Combinational fetch; reads during a write see the old word until the edge.
    always_comb
        instruction = (program_counter < 32'(DEPTH)) ? mem[program_counter[ADDR_W-1:0]] : 32'h0000_0000;
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: directed scenario checks for the instruction loader
module tb_instruction_loader;
    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic [8:0]  load_count;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] program_counter;
    logic [31:0] instruction;
    logic        busy;
    logic        done;
    logic [8:0]  words_loaded;
    int tests = 0;
    int fails = 0;

    instruction_loader dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_count(load_count),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .program_counter(program_counter), .instruction(instruction),
        .busy(busy), .done(done), .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    // Drive one cycle of inputs at a falling edge and return at the next falling edge.
    task automatic cycle(input logic ls, input logic [8:0] cnt, input logic bv, input logic [7:0] b);
        load_start = ls; load_count = cnt; byte_valid = bv; byte_in = b;
        @(negedge clk);
    endtask

    task automatic test_reset;
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 8'h5A);
        tests++; if (byte_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", byte_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (words_loaded !== 9'd0) begin fails++; $display("FAIL reset_words got %0d want 0", words_loaded); end
        rst_n = 1'b1;
        cycle(0, 0, 1, 8'h5A);
        tests++; if (byte_ready !== 1'b0) begin fails++; $display("FAIL idle_ready got %b want 0", byte_ready); end
        tests++; if (words_loaded !== 9'd0) begin fails++; $display("FAIL idle_words got %0d want 0", words_loaded); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] b [8];
        b = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'hA2, 8'h00, 8'h04};
        cycle(1, 9'd2, 0, 0);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy got %b want 1", busy); end
        tests++; if (byte_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got %b want 1", byte_ready); end
        tests++; if (words_loaded !== 9'd0) begin fails++; $display("FAIL b2b_words0 got %0d want 0", words_loaded); end
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 1, b[i]);
            if (i == 3) begin
                tests++; if (words_loaded !== 9'd1) begin fails++; $display("FAIL b2b_words1 got %0d want 1", words_loaded); end
            end
            if (i == 6) begin
                tests++; if (done !== 1'b0) begin fails++; $display("FAIL b2b_early_done got %b want 0", done); end
            end
        end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_done got %b want 1", done); end
        tests++; if (byte_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_after got %b want 0", byte_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_after got %b want 0", busy); end
        tests++; if (words_loaded !== 9'd2) begin fails++; $display("FAIL b2b_words2 got %0d want 2", words_loaded); end
        cycle(0, 0, 1, 8'h99);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_done_hold got %b want 1", done); end
        cycle(0, 0, 0, 0);
        program_counter = 32'd0; #1;
        tests++; if (instruction !== 32'h2008_0005) begin fails++; $display("FAIL b2b_mem0 got %h want 20080005", instruction); end
        program_counter = 32'd1; #1;
        tests++; if (instruction !== 32'h8CA2_0004) begin fails++; $display("FAIL b2b_mem1 got %h want 8ca20004", instruction); end
    endtask

    task automatic test_valid_toggle;
        logic [7:0] b [4];
        b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        cycle(1, 9'd1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            if (i % 2 == 0) cycle(0, 0, 1, b[i / 2]);
            else cycle(0, 0, 0, 8'hFF);
            tests++; if (done !== (i == 6)) begin fails++; $display("FAIL toggle_done step %0d got %b want %b", i, done, i == 6); end
        end
        tests++; if (words_loaded !== 9'd1) begin fails++; $display("FAIL toggle_words got %0d want 1", words_loaded); end
        cycle(0, 0, 0, 0);
        program_counter = 32'd0; #1;
        tests++; if (instruction !== 32'hDEAD_BEEF) begin fails++; $display("FAIL toggle_mem0 got %h want deadbeef", instruction); end
        program_counter = 32'd1; #1;
        tests++; if (instruction !== 32'h8CA2_0004) begin fails++; $display("FAIL toggle_mem1 got %h want 8ca20004", instruction); end
    endtask

    task automatic test_reset_mid_word;
        cycle(1, 9'd1, 0, 0);
        cycle(0, 0, 1, 8'h55);
        cycle(0, 0, 1, 8'h66);
        rst_n = 1'b0; #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", busy); end
        tests++; if (byte_ready !== 1'b0) begin fails++; $display("FAIL rstmid_ready got %b want 0", byte_ready); end
        tests++; if (words_loaded !== 9'd0) begin fails++; $display("FAIL rstmid_words got %0d want 0", words_loaded); end
        cycle(0, 0, 1, 8'h77);
        rst_n = 1'b1;
        cycle(0, 0, 1, 8'h88);
        cycle(0, 0, 1, 8'h99);
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rstmid_idle got busy %b done %b want 0 0", busy, done); end
        program_counter = 32'd0; #1;
        tests++; if (instruction !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rstmid_mem0 got %h want deadbeef", instruction); end
        cycle(0, 0, 0, 0);
    endtask

    task automatic test_zero_count;
        cycle(1, 9'd0, 1, 8'h12);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL zero_done got %b want 1", done); end
        tests++; if (byte_ready !== 1'b0) begin fails++; $display("FAIL zero_ready got %b want 0", byte_ready); end
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 8'h34);
        tests++; if (byte_ready !== 1'b0 || words_loaded !== 9'd0) begin fails++; $display("FAIL zero_hold got ready %b words %0d want 0 0", byte_ready, words_loaded); end
        program_counter = 32'd0; #1;
        tests++; if (instruction !== 32'hDEAD_BEEF) begin fails++; $display("FAIL zero_mem0 got %h want deadbeef", instruction); end
        cycle(0, 0, 0, 0);
    endtask

    task automatic test_clamp;
        cycle(1, 9'd300, 0, 0);
        for (int k = 0; k < 1024; k++) begin
            cycle(0, 0, 1, 8'(k));
            if (k == 1022) begin
                tests++; if (done !== 1'b0 || words_loaded !== 9'd255) begin fails++; $display("FAIL clamp_pre got done %b words %0d want 0 255", done, words_loaded); end
            end
        end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL clamp_done got %b want 1", done); end
        tests++; if (words_loaded !== 9'd256) begin fails++; $display("FAIL clamp_words got %0d want 256", words_loaded); end
        cycle(0, 0, 0, 0);
        program_counter = 32'd0; #1;
        tests++; if (instruction !== 32'h0001_0203) begin fails++; $display("FAIL clamp_mem0 got %h want 00010203", instruction); end
        program_counter = 32'd100; #1;
        tests++; if (instruction !== 32'h9091_9293) begin fails++; $display("FAIL clamp_mem100 got %h want 90919293", instruction); end
        program_counter = 32'd255; #1;
        tests++; if (instruction !== 32'hFCFD_FEFF) begin fails++; $display("FAIL clamp_mem255 got %h want fcfdfeff", instruction); end
    endtask

    task automatic test_out_of_range;
        cycle(0, 0, 0, 0);
        program_counter = 32'h100; #1;
        tests++; if (instruction !== 32'h0) begin fails++; $display("FAIL oor_100 got %h want 0", instruction); end
        program_counter = 32'h1FF; #1;
        tests++; if (instruction !== 32'h0) begin fails++; $display("FAIL oor_1ff got %h want 0", instruction); end
        program_counter = 32'hFFFF_FFFF; #1;
        tests++; if (instruction !== 32'h0) begin fails++; $display("FAIL oor_max got %h want 0", instruction); end
    endtask

    task automatic test_read_during_write;
        cycle(1, 9'd1, 0, 0);
        program_counter = 32'd0;
        cycle(0, 0, 1, 8'hA1);
        cycle(0, 0, 1, 8'hB2);
        cycle(0, 0, 1, 8'hC3);
        load_start = 1'b0; byte_valid = 1'b1; byte_in = 8'hD4; #1;
        tests++; if (instruction !== 32'h0001_0203) begin fails++; $display("FAIL rdw_old got %h want 00010203", instruction); end
        @(negedge clk);
        tests++; if (instruction !== 32'hA1B2_C3D4) begin fails++; $display("FAIL rdw_new got %h want a1b2c3d4", instruction); end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL rdw_done got %b want 1", done); end
        cycle(0, 0, 0, 0);
    endtask

    task automatic test_restart_priority;
        cycle(1, 9'd1, 1, 8'hEE);
        tests++; if (busy !== 1'b1 || words_loaded !== 9'd0) begin fails++; $display("FAIL rst_from_done got busy %b words %0d want 1 0", busy, words_loaded); end
        cycle(0, 0, 1, 8'h11);
        cycle(0, 0, 1, 8'h22);
        cycle(1, 9'd1, 1, 8'h33);
        tests++; if (busy !== 1'b1 || words_loaded !== 9'd0) begin fails++; $display("FAIL restart_state got busy %b words %0d want 1 0", busy, words_loaded); end
        cycle(0, 0, 1, 8'h44);
        cycle(0, 0, 1, 8'h55);
        cycle(0, 0, 1, 8'h66);
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL restart_early_done got %b want 0", done); end
        cycle(0, 0, 1, 8'h77);
        tests++; if (done !== 1'b1 || words_loaded !== 9'd1) begin fails++; $display("FAIL restart_done got done %b words %0d want 1 1", done, words_loaded); end
        cycle(0, 0, 0, 0);
        program_counter = 32'd0; #1;
        tests++; if (instruction !== 32'h4455_6677) begin fails++; $display("FAIL restart_mem0 got %h want 44556677", instruction); end
        program_counter = 32'd1; #1;
        tests++; if (instruction !== 32'h0405_0607) begin fails++; $display("FAIL restart_mem1 got %h want 04050607", instruction); end
    endtask

    initial begin
        rst_n = 1'b0; load_start = 1'b0; load_count = '0; byte_in = '0; byte_valid = 1'b0; program_counter = '0;
        test_reset;
        test_back_to_back;
        test_valid_toggle;
        test_reset_mid_word;
        test_zero_count;
        test_clamp;
        test_out_of_range;
        test_read_during_write;
        test_restart_priority;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
